vector_fetch_sequencer: RTL and testbench
=========================================

VECTOR_FETCH_SEQUENCER -- requirements
Module: vector_fetch_sequencer

Interface
REQ-001 SHALL have port sys_clock  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port clk_ph2_enable  in  1  step qualifier; state advances only on edges where it is 1.
REQ-004 SHALL have ports res_req, brk_req, instr_boundary, i_flag  in  1 each  reset request, BRK request, boundary strobe, interrupt-disable flag.
REQ-005 SHALL have ports nmi_n, irq_n  in  1 each  NMI (falling-edge sensitive), IRQ (level, active-low).
REQ-006 SHALL have ports PCL_in, PCH_in, sp_in, status_in, data_in  in  8 each  current PC bytes, stack pointer, P register, read data bus.
REQ-007 SHALL have ports addr_out  out  16, data_out  out  8, rw_out  out  1  bus address, write data, 1 = read.
REQ-008 SHALL have ports ADL_out, ADH_out  out  8 each, and ADL_in_en, ADH_in_en, PCL_in_enable, PCH_in_enable, INC_en  out  1 each  program counter load and control.
REQ-009 SHALL have ports sp_dec, set_i, busy, seq_done  out  1 each  SP decrement, set I flag, sequence active, one-cycle completion pulse.

Function
REQ-010 SHALL implement states IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD_PC; every transition is gated by clk_ph2_enable.
REQ-011 SHALL leave IDLE only when instr_boundary=1 and a request is pending; priority: RES > NMI > BRK > IRQ.
REQ-012 SHALL treat IRQ as pending only while irq_n=0 and i_flag=0; it SHALL latch NMI on a 1->0 transition of nmi_n, sampled on enabled edges, and clear the latch on entry to VEC_LO.
REQ-013 SHALL, in PUSH_PCH/PUSH_PCL/PUSH_P, drive addr_out={8'h01,sp_in}, rw_out=0, data_out=PCH_in/PCL_in/status_in, and sp_dec=1.
REQ-014 SHALL force bit 4 of the pushed P to 1 for BRK and to 0 for NMI/IRQ.
REQ-015 SHALL, for RES, hold rw_out=1 in all three push states while still asserting sp_dec.
REQ-016 SHALL select vector base FFFA (NMI), FFFC (RES), FFFE (IRQ/BRK); VEC_LO reads base, VEC_HI reads base+1, with rw_out=1.
REQ-017 SHALL switch the vector to FFFA (NMI hijack) when an NMI latches during IRQ/BRK before VEC_LO is entered.
REQ-018 SHALL capture data_in at VEC_LO/VEC_HI into ADL_out/ADH_out, and in LOAD_PC assert ADL_in_en, ADH_in_en, set_i, and seq_done for exactly one enabled cycle, then return to IDLE.
REQ-019 SHALL hold INC_en=0 while busy and PCL_in_enable=PCH_in_enable=0 in every state.
REQ-020 SHALL keep busy=1 in all states except IDLE; a sequence is 6 enabled cycles from leaving IDLE to seq_done.
REQ-021 SHALL, when res_req asserts mid-sequence, abort to PUSH_PCH with vector FFFC on the next enabled edge.

Reset
REQ-022 SHALL, while reset=0, force IDLE, clear the NMI latch, and drive every output to 0 except rw_out=1.
REQ-023 SHALL start a RES sequence on the first enabled edge after reset release, regardless of res_req.

Configuration
REQ-024 SHALL, when VECTOR_FETCH_BRK_EN is defined, honour brk_req per REQ-011/014; when undefined, ignore brk_req and never set pushed bit 4.

Structure
REQ-025 SHALL take the state enumeration, vector constants (FFFA/FFFC/FFFE) and the stack page constant from shared package cpu_pkg.
REQ-026 SHALL place NMI edge detection and request priority in sub-module int_request_arbiter; everything else stays in this module.

Verification
REQ-027 Reset release, data_in=34 at FFFC, 12 at FFFD -> three reads at 01FF/01FE/01FD, ADH/ADL=12/34, seq_done after 6 enabled cycles.
REQ-028 PC=C123, sp_in=FD, P=24, irq_n=0, i_flag=0, boundary -> writes C1@01FD, 23@01FC, 24@01FB, reads FFFE/FFFF, set_i=1.
REQ-029 irq_n=0 with i_flag=1 -> busy stays 0; brk_req=1 -> pushed P=34, vector FFFE (macro defined); busy stays 0 (undefined).
REQ-030 IRQ sequence, nmi_n falls during PUSH_PCL -> vector reads FFFA/FFFB, pushed bit 4=0.
REQ-031 clk_ph2_enable toggling every third edge -> identical bus sequence, one state per enabled edge.
REQ-032 res_req=1 during VEC_HI of IRQ -> next enabled edge in PUSH_PCH, rw_out=1, final vector FFFC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer states, request kinds, vector and stack constants.
// Ports: none (package). Optional BRK support is selected by VECTOR_FETCH_BRK_EN.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_LO,
    VEC_HI,
    LOAD_PC
  } seq_state_t;

  typedef enum logic [1:0] {
    KIND_RES,
    KIND_NMI,
    KIND_BRK,
    KIND_IRQ
  } req_kind_t;

  localparam logic [15:0] VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] VEC_RES    = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE = 8'h01;

  function automatic logic [15:0] vec_base(req_kind_t k);
    logic [15:0] v;
    v = VEC_IRQ;
    case (k)
      KIND_RES: v = VEC_RES;
      KIND_NMI: v = VEC_NMI;
      default:  v = VEC_IRQ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/int_request_arbiter.sv
// int_request_arbiter: NMI falling-edge latch and RES > NMI > BRK > IRQ priority.
// Ports: i_clk/i_rst_n/i_step, request inputs, i_nmi_clr; o_req, o_nmi, o_kind. Macro: VECTOR_FETCH_BRK_EN.
module int_request_arbiter
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic       i_res,
  input  logic       i_nmi_n,
  input  logic       i_brk,
  input  logic       i_irq_n,
  input  logic       i_i_flag,
  input  logic       i_nmi_clr,
  output logic       o_req,
  output logic       o_nmi,
  output logic [1:0] o_kind
);

  logic r_nmi_prev;
  logic r_nmi_lat;
  logic w_fall;
  logic w_irq;
  logic w_brk;

`ifdef VECTOR_FETCH_BRK_EN
  assign w_brk = i_brk;
`else
  assign w_brk = 1'b0 & i_brk;
`endif

  assign w_fall = r_nmi_prev & ~i_nmi_n;
  // A fresh edge counts as pending in the same cycle it is seen.
  assign o_nmi  = r_nmi_lat | w_fall;
  assign w_irq  = ~i_irq_n & ~i_i_flag;
  assign o_req  = i_res | o_nmi | w_brk | w_irq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nmi_prev <= 1'b1;
      r_nmi_lat  <= 1'b0;
    end else if (i_step) begin
      r_nmi_prev <= i_nmi_n;
      if (i_nmi_clr)
        r_nmi_lat <= 1'b0;
      else if (w_fall)
        r_nmi_lat <= 1'b1;
    end
  end

  always_comb begin
    o_kind = KIND_IRQ;
    if (i_res)
      o_kind = KIND_RES;
    else if (o_nmi)
      o_kind = KIND_NMI;
    else if (w_brk)
      o_kind = KIND_BRK;
  end

endmodule

// File: rtl/vector_fetch_sequencer.sv
// vector_fetch_sequencer: interrupt/reset entry sequence (push PC,P; fetch vector; load PC).
// Ports: sys_clock/reset/clk_ph2_enable, requests, PC/SP/P/data in; bus, PC load, SP/flag strobes out. Macro: VECTOR_FETCH_BRK_EN.
module vector_fetch_sequencer
  import cpu_pkg::*;
(
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        clk_ph2_enable,
  input  logic        res_req,
  input  logic        brk_req,
  input  logic        instr_boundary,
  input  logic        i_flag,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic [7:0]  PCL_in,
  input  logic [7:0]  PCH_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  status_in,
  input  logic [7:0]  data_in,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        rw_out,
  output logic [7:0]  ADL_out,
  output logic [7:0]  ADH_out,
  output logic        ADL_in_en,
  output logic        ADH_in_en,
  output logic        PCL_in_enable,
  output logic        PCH_in_enable,
  output logic        INC_en,
  output logic        sp_dec,
  output logic        set_i,
  output logic        busy,
  output logic        seq_done
);

  seq_state_t  r_state;
  seq_state_t  w_next;
  req_kind_t   r_kind;
  logic [15:0] r_vec;
  logic [7:0]  r_adl;
  logic [7:0]  r_adh;
  logic        r_por;
  logic        w_req;
  logic        w_nmi;
  logic [1:0]  w_kind;
  logic        w_start;
  logic        w_nmi_clr;
  logic        w_hijack;
  logic        w_res;
  logic        w_p_b;
  logic [7:0]  w_p;

  // Power-on RES is folded into the reset request so it wins priority.
  int_request_arbiter u_arb (
    .i_clk     (sys_clock),
    .i_rst_n   (reset),
    .i_step    (clk_ph2_enable),
    .i_res     (res_req | r_por),
    .i_nmi_n   (nmi_n),
    .i_brk     (brk_req),
    .i_irq_n   (irq_n),
    .i_i_flag  (i_flag),
    .i_nmi_clr (w_nmi_clr),
    .o_req     (w_req),
    .o_nmi     (w_nmi),
    .o_kind    (w_kind)
  );

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else if (clk_ph2_enable)
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (r_por || (instr_boundary && w_req))
          w_next = PUSH_PCH;
      PUSH_PCH: w_next = PUSH_PCL;
      PUSH_PCL: w_next = PUSH_P;
      PUSH_P:   w_next = VEC_LO;
      VEC_LO:   w_next = VEC_HI;
      VEC_HI:   w_next = LOAD_PC;
      LOAD_PC:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    if (r_state != IDLE && res_req)
      w_next = PUSH_PCH;
  end

  // PUSH_PCH is only ever entered by a start or a RES abort.
  assign w_start   = (w_next == PUSH_PCH);
  assign w_nmi_clr = (r_state == PUSH_P) && (w_next == VEC_LO);
  assign w_hijack  = w_nmi_clr && w_nmi &&
                     (r_kind == KIND_IRQ || r_kind == KIND_BRK);

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      r_kind <= KIND_RES;
      r_vec  <= VEC_RES;
      r_adl  <= 8'h00;
      r_adh  <= 8'h00;
      r_por  <= 1'b1;
    end else if (clk_ph2_enable) begin
      r_por <= 1'b0;
      if (w_start) begin
        r_kind <= req_kind_t'(w_kind);
        r_vec  <= vec_base(req_kind_t'(w_kind));
      end else if (w_hijack) begin
        r_vec <= VEC_NMI;
      end
      if (r_state == VEC_LO)
        r_adl <= data_in;
      if (r_state == VEC_HI)
        r_adh <= data_in;
    end
  end

`ifdef VECTOR_FETCH_BRK_EN
  assign w_p_b = (r_kind == KIND_BRK);
`else
  assign w_p_b = 1'b0;
`endif

  assign w_res = (r_kind == KIND_RES);
  assign w_p   = (status_in & 8'hEF) | {3'b000, w_p_b, 4'h0};

  always_comb begin
    addr_out  = 16'h0000;
    data_out  = 8'h00;
    rw_out    = 1'b1;
    sp_dec    = 1'b0;
    ADL_in_en = 1'b0;
    ADH_in_en = 1'b0;
    set_i     = 1'b0;
    seq_done  = 1'b0;
    unique case (r_state)
      PUSH_PCH: begin
        addr_out = {STACK_PAGE, sp_in};
        sp_dec   = 1'b1;
        rw_out   = w_res;
        data_out = w_res ? 8'h00 : PCH_in;
      end
      PUSH_PCL: begin
        addr_out = {STACK_PAGE, sp_in};
        sp_dec   = 1'b1;
        rw_out   = w_res;
        data_out = w_res ? 8'h00 : PCL_in;
      end
      PUSH_P: begin
        addr_out = {STACK_PAGE, sp_in};
        sp_dec   = 1'b1;
        rw_out   = w_res;
        data_out = w_res ? 8'h00 : w_p;
      end
      VEC_LO: addr_out = r_vec;
      VEC_HI: addr_out = r_vec + 16'd1;
      LOAD_PC: begin
        ADL_in_en = 1'b1;
        ADH_in_en = 1'b1;
        set_i     = 1'b1;
        seq_done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy          = (r_state != IDLE);
  assign ADL_out       = r_adl;
  assign ADH_out       = r_adh;
  // PC increment and direct PC byte loads belong to the core, not here.
  assign INC_en        = 1'b0;
  assign PCL_in_enable = 1'b0;
  assign PCH_in_enable = 1'b0;

endmodule

// File: tb/tb_vector_fetch_sequencer.sv
// tb_vector_fetch_sequencer: random stimulus, queue scoreboard, monitor on negedge.
// Expected bus cycles come from a sequence-level model of the entry protocol.
module tb_vector_fetch_sequencer;

  localparam int K_RES = 0;
  localparam int K_NMI = 1;
  localparam int K_BRK = 2;
  localparam int K_IRQ = 3;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
    logic        spd;
    logic        done;
    logic [15:0] pc;
  } ev_t;

  logic        sys_clock = 1'b0;
  logic        reset = 1'b0;
  logic        clk_ph2_enable = 1'b1;
  logic        res_req = 1'b0;
  logic        brk_req = 1'b0;
  logic        instr_boundary = 1'b0;
  logic        i_flag = 1'b0;
  logic        nmi_n = 1'b1;
  logic        irq_n = 1'b1;
  logic [7:0]  PCL_in = 8'h00;
  logic [7:0]  PCH_in = 8'h00;
  logic [7:0]  sp_in;
  logic [7:0]  status_in = 8'h00;
  logic [7:0]  data_in;
  logic [15:0] addr_out;
  logic [7:0]  data_out;
  logic        rw_out;
  logic [7:0]  ADL_out;
  logic [7:0]  ADH_out;
  logic        ADL_in_en;
  logic        ADH_in_en;
  logic        PCL_in_enable;
  logic        PCH_in_enable;
  logic        INC_en;
  logic        sp_dec;
  logic        set_i;
  logic        busy;
  logic        seq_done;

  ev_t         q[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [7:0]  vmem[6];
  int          en_mode = 0;
  int          en_cnt = 0;
  logic [7:0]  sp_base = 8'hFF;
  logic [7:0]  dec_cnt = 8'h00;
  logic        dec_pend = 1'b0;

  vector_fetch_sequencer dut (
    .sys_clock      (sys_clock),
    .reset          (reset),
    .clk_ph2_enable (clk_ph2_enable),
    .res_req        (res_req),
    .brk_req        (brk_req),
    .instr_boundary (instr_boundary),
    .i_flag         (i_flag),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .PCL_in         (PCL_in),
    .PCH_in         (PCH_in),
    .sp_in          (sp_in),
    .status_in      (status_in),
    .data_in        (data_in),
    .addr_out       (addr_out),
    .data_out       (data_out),
    .rw_out         (rw_out),
    .ADL_out        (ADL_out),
    .ADH_out        (ADH_out),
    .ADL_in_en      (ADL_in_en),
    .ADH_in_en      (ADH_in_en),
    .PCL_in_enable  (PCL_in_enable),
    .PCH_in_enable  (PCH_in_enable),
    .INC_en         (INC_en),
    .sp_dec         (sp_dec),
    .set_i          (set_i),
    .busy           (busy),
    .seq_done       (seq_done)
  );

  always #5 sys_clock = ~sys_clock;

  // Vector ROM at FFFA..FFFF; everything else reads as EE.
  always_comb begin
    data_in = 8'hEE;
    for (int i = 0; i < 6; i++)
      if (addr_out == 16'hFFFA + 16'(i))
        data_in = vmem[i];
  end

  // Stack pointer behaves like the core's SP: one decrement per enabled sp_dec.
  assign sp_in = sp_base - dec_cnt;

  always @(negedge sys_clock)
    dec_pend = reset && clk_ph2_enable && sp_dec;

  always @(posedge sys_clock) begin
    #1;
    if (dec_pend)
      dec_cnt = dec_cnt + 8'd1;
  end

  always @(posedge sys_clock) begin
    #1;
    en_cnt++;
    case (en_mode)
      0: clk_ph2_enable = 1'b1;
      1: clk_ph2_enable = ((en_cnt % 3) == 0);
      default: clk_ph2_enable = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge sys_clock) begin : monitor
    ev_t e;
    if (reset && busy && clk_ph2_enable) begin
      chk("pc_ctrl_low", 32'({INC_en, PCL_in_enable, PCH_in_enable}), 32'd0);
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_cycle: addr %h rw %b, none expected",
                 addr_out, rw_out);
      end else begin
        e = q.pop_front();
        if (!e.done)
          chk("addr", 32'(addr_out), 32'(e.addr));
        chk("rw", 32'(rw_out), 32'(e.rw));
        if (!e.rw)
          chk("wdata", 32'(data_out), 32'(e.data));
        chk("sp_dec", 32'(sp_dec), 32'(e.spd));
        chk("done_flags",
            32'({seq_done, set_i, ADL_in_en, ADH_in_en}),
            e.done ? 32'hF : 32'h0);
        if (e.done)
          chk("vector_pc", 32'({ADH_out, ADL_out}), 32'(e.pc));
      end
    end
  end

  // Sequence-level model: three stack cycles, two vector reads, PC load.
  task automatic push_seq(input int kind, input logic [15:0] pc,
                          input logic [7:0] sp, input logic [7:0] p,
                          input int vkind, input int n);
    ev_t ev[6];
    logic [7:0] pp;
    logic [7:0] s;
    logic [15:0] vb;
    int vi;
    pp = (kind == K_BRK) ? (p | 8'h10) : (p & 8'hEF);
    vb = (vkind == K_RES) ? 16'hFFFC :
         (vkind == K_NMI) ? 16'hFFFA : 16'hFFFE;
    vi = int'(vb - 16'hFFFA);
    for (int i = 0; i < 3; i++) begin
      s = sp - 8'(i);
      ev[i].addr = {8'h01, s};
      ev[i].rw   = (kind == K_RES);
      ev[i].data = (i == 0) ? pc[15:8] : (i == 1) ? pc[7:0] : pp;
      ev[i].spd  = 1'b1;
      ev[i].done = 1'b0;
      ev[i].pc   = 16'h0;
    end
    for (int i = 3; i < 5; i++) begin
      ev[i].addr = vb + 16'(i - 3);
      ev[i].rw   = 1'b1;
      ev[i].data = 8'h00;
      ev[i].spd  = 1'b0;
      ev[i].done = 1'b0;
      ev[i].pc   = 16'h0;
    end
    ev[5].addr = 16'h0;
    ev[5].rw   = 1'b1;
    ev[5].data = 8'h00;
    ev[5].spd  = 1'b0;
    ev[5].done = 1'b1;
    ev[5].pc   = {vmem[vi + 1], vmem[vi]};
    for (int i = 0; i < n; i++)
      q.push_back(ev[i]);
  endtask

  task automatic wait_en();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(posedge sys_clock);
      got = clk_ph2_enable;
    end
    #2;
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL enable_timeout: got none expected an enabled edge");
    end
  endtask

  task automatic start_seq();
    instr_boundary = 1'b1;
    wait_en();
    instr_boundary = 1'b0;
  endtask

  task automatic finish_seq();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 400) begin
      @(negedge sys_clock);
      t++;
    end
    #2;
    chk("seq_complete", 32'({q.size() == 0, busy}), 32'd2);
    q.delete();
  endtask

  task automatic set_cpu(input logic [15:0] pc, input logic [7:0] sp,
                         input logic [7:0] p);
    PCH_in    = pc[15:8];
    PCL_in    = pc[7:0];
    status_in = p;
    sp_base   = sp + dec_cnt;
  endtask

  task automatic idle_checks(input string nm);
    for (int i = 0; i < 6; i++) begin
      wait_en();
      chk(nm, 32'(busy), 32'd0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [7:0]  p;
    int          k;
    for (int i = 0; i < 6; i++)
      vmem[i] = 8'($urandom);
    vmem[2] = 8'h34;
    vmem[3] = 8'h12;

    repeat (3) @(negedge sys_clock);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_rw_data", 32'({rw_out, data_out}), 32'h100);
    chk("rst_flags",
        32'({busy, seq_done, set_i, sp_dec, ADL_in_en, ADH_in_en,
             PCL_in_enable, PCH_in_enable, INC_en}), 32'd0);
    chk("rst_ad", 32'({ADH_out, ADL_out}), 32'd0);

    // Power-on RES without res_req or boundary.
    push_seq(K_RES, 16'h0000, 8'hFF, 8'h00, K_RES, 6);
    @(posedge sys_clock);
    #1 reset = 1'b1;
    finish_seq();

    // IRQ with the reference values.
    set_cpu(16'hC123, 8'hFD, 8'h24);
    irq_n = 1'b0;
    push_seq(K_IRQ, 16'hC123, 8'hFD, 8'h24, K_IRQ, 6);
    start_seq();
    finish_seq();
    irq_n = 1'b1;
    wait_en();

    // IRQ masked by the I flag.
    irq_n = 1'b0;
    i_flag = 1'b1;
    instr_boundary = 1'b1;
    idle_checks("irq_masked_idle");
    instr_boundary = 1'b0;
    irq_n = 1'b1;
    i_flag = 1'b0;

    // BRK request.
    set_cpu(16'h8000, 8'hF0, 8'h24);
    brk_req = 1'b1;
`ifdef VECTOR_FETCH_BRK_EN
    push_seq(K_BRK, 16'h8000, 8'hF0, 8'h24, K_BRK, 6);
    start_seq();
    brk_req = 1'b0;
    finish_seq();
`else
    instr_boundary = 1'b1;
    idle_checks("brk_ignored_idle");
    instr_boundary = 1'b0;
    brk_req = 1'b0;
`endif
    wait_en();

    // NMI arrives during PUSH_PCL of an IRQ and takes over the vector.
    set_cpu(16'h4567, 8'hE0, 8'h30);
    irq_n = 1'b0;
    push_seq(K_IRQ, 16'h4567, 8'hE0, 8'h30, K_NMI, 6);
    start_seq();
    wait_en();
    nmi_n = 1'b0;
    finish_seq();
    irq_n = 1'b1;
    nmi_n = 1'b1;
    wait_en();

    // Sparse enable: one enabled edge in three.
    en_mode = 1;
    for (int r = 0; r < 2; r++) begin
      pc = 16'($urandom);
      sp = 8'($urandom);
      p  = 8'($urandom);
      set_cpu(pc, sp, p);
      irq_n = 1'b0;
      push_seq(K_IRQ, pc, sp, p, K_IRQ, 6);
      start_seq();
      finish_seq();
      irq_n = 1'b1;
      wait_en();
    end
    en_mode = 0;

    // RES during VEC_HI of an IRQ aborts into a fresh RES entry.
    set_cpu(16'hA55A, 8'hC8, 8'h01);
    irq_n = 1'b0;
    push_seq(K_IRQ, 16'hA55A, 8'hC8, 8'h01, K_IRQ, 5);
    push_seq(K_RES, 16'hA55A, 8'hC5, 8'h01, K_RES, 6);
    start_seq();
    repeat (4) wait_en();
    res_req = 1'b1;
    wait_en();
    res_req = 1'b0;
    chk("abort_push_pch", 32'({rw_out, sp_dec, addr_out}),
        32'({1'b1, 1'b1, 16'h01C5}));
    finish_seq();
    irq_n = 1'b1;
    wait_en();

    // Random kinds, operands, vectors and enable patterns.
    for (int r = 0; r < 20; r++) begin
      en_mode = $urandom_range(0, 2);
      for (int i = 0; i < 6; i++)
        vmem[i] = 8'($urandom);
      pc = 16'($urandom);
      sp = 8'($urandom);
      p  = 8'($urandom);
      k  = $urandom_range(0, 3);
`ifndef VECTOR_FETCH_BRK_EN
      if (k == K_BRK)
        k = K_IRQ;
`endif
      set_cpu(pc, sp, p);
      push_seq(k, pc, sp, p, k, 6);
      case (k)
        K_RES: res_req = 1'b1;
        K_NMI: nmi_n = 1'b0;
        K_BRK: brk_req = 1'b1;
        default: irq_n = 1'b0;
      endcase
      start_seq();
      res_req = 1'b0;
      brk_req = 1'b0;
      finish_seq();
      irq_n = 1'b1;
      nmi_n = 1'b1;
      wait_en();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
